// File: rtl/prbs_pkg.sv
// Shared PRBS9 definitions for the lfsr_9bit generator and prbs9_checker.
// Polynomial x^9 + x^5 + 1; register bit 0 holds the newest bit.
package prbs_pkg;

  localparam int PRBS9_LEN   = 9;
  localparam int PRBS9_TAP_A = 8;
  localparam int PRBS9_TAP_B = 4;

  typedef enum logic {
    CHK_SEARCH,
    CHK_LOCKED
  } chk_state_t;

  // Advance a PRBS9 history register by one bit; the new bit lands in bit 0.
  function automatic logic [PRBS9_LEN-1:0] prbs9_next(input logic [PRBS9_LEN-1:0] s);
    return {s[PRBS9_LEN-2:0], s[PRBS9_TAP_A] ^ s[PRBS9_TAP_B]};
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] value
);

  // Count up on inc, stick at all-ones, clear wins over a simultaneous increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
    end else if (clr) begin
      value <= '0;
    end else if (inc && (value != {W{1'b1}})) begin
      value <= value + W'(1);
    end
  end

endmodule

// File: rtl/prbs9_checker.sv
// Serial PRBS9 receiver/checker: self-synchronises to the incoming bit stream,
// then flags and counts bit errors, dropping lock on an excessive error burst.
// Optional feature macro PRBS9_CHK_BIT_CNT_EN adds bit_cnt_o, the number of
// qualified bits seen while locked, so BER = err_cnt_o / bit_cnt_o.
module prbs9_checker
  import prbs_pkg::*;
#(
  parameter int LOCK_MATCHES = 16,
  parameter int LOSS_WINDOW  = 64,
  parameter int LOSS_ERRORS  = 8,
  parameter int ERR_CNT_W    = 32
) (
  input  logic                 clk_i,
  input  logic                 a_rst_n_i,
  input  logic                 clr_i,
  input  logic                 data_i,
  input  logic                 valid_i,
  output logic                 locked_o,
  output logic                 err_o,
  output logic [ERR_CNT_W-1:0] err_cnt_o,
  output logic                 lock_lost_o
`ifdef PRBS9_CHK_BIT_CNT_EN
  ,
  output logic [ERR_CNT_W-1:0] bit_cnt_o
`endif
);

  localparam int MC_W = $clog2(LOCK_MATCHES + 1);
  localparam int WB_W = $clog2(LOSS_WINDOW + 1);
  localparam int WE_W = $clog2(LOSS_ERRORS + 1);

  localparam logic [MC_W-1:0] MATCH_TARGET = MC_W'(LOCK_MATCHES);
  localparam logic [WB_W-1:0] WIN_LAST     = WB_W'(LOSS_WINDOW - 1);
  localparam logic [WE_W-1:0] ERR_LIMIT    = WE_W'(LOSS_ERRORS);

  chk_state_t           state, state_nx;
  logic [PRBS9_LEN-1:0] shreg, shreg_nx, ref_nx;
  logic [MC_W-1:0]      match_cnt, match_cnt_nx;
  logic [WB_W-1:0]      win_bit, win_bit_nx;
  logic [WE_W-1:0]      win_err, win_err_nx, win_err_inc;
  logic                 predict;
  logic                 bit_err;
  logic                 err_nx, lost_nx;
  logic                 err_r, lost_r;
  logic                 err_inc;

  // The locally predicted next bit is the newest bit of the advanced reference.
  assign ref_nx  = prbs9_next(shreg);
  assign predict = ref_nx[0];
  assign bit_err = data_i ^ predict;

  // Next-state logic: search for a run of correct predictions, then track errors
  // against a free-running reference and drop lock when a window collects too many.
  always_comb begin
    state_nx     = state;
    shreg_nx     = shreg;
    match_cnt_nx = match_cnt;
    win_bit_nx   = win_bit;
    win_err_nx   = win_err;
    err_nx       = 1'b0;
    lost_nx      = 1'b0;
    win_err_inc  = win_err + WE_W'(bit_err);

    if (valid_i) begin
      case (state)
        CHK_SEARCH: begin
          shreg_nx = {shreg[PRBS9_LEN-2:0], data_i};
          if (!bit_err && (shreg != '0)) begin
            if ((match_cnt + MC_W'(1)) == MATCH_TARGET) begin
              state_nx     = CHK_LOCKED;
              match_cnt_nx = '0;
              win_bit_nx   = '0;
              win_err_nx   = '0;
            end else begin
              match_cnt_nx = match_cnt + MC_W'(1);
            end
          end else begin
            match_cnt_nx = '0;
          end
        end

        CHK_LOCKED: begin
          shreg_nx = ref_nx;
          err_nx   = bit_err;
          if (win_err_inc == ERR_LIMIT) begin
            state_nx     = CHK_SEARCH;
            lost_nx      = 1'b1;
            match_cnt_nx = '0;
            win_bit_nx   = '0;
            win_err_nx   = '0;
          end else if (win_bit == WIN_LAST) begin
            win_bit_nx = '0;
            win_err_nx = '0;
          end else begin
            win_bit_nx = win_bit + WB_W'(1);
            win_err_nx = win_err_inc;
          end
        end

        default: begin
          state_nx = CHK_SEARCH;
        end
      endcase
    end
  end

  // State, history and window registers plus the registered pulse outputs.
  always_ff @(posedge clk_i or negedge a_rst_n_i) begin
    if (!a_rst_n_i) begin
      state     <= CHK_SEARCH;
      shreg     <= '0;
      match_cnt <= '0;
      win_bit   <= '0;
      win_err   <= '0;
      err_r     <= 1'b0;
      lost_r    <= 1'b0;
    end else begin
      state     <= state_nx;
      shreg     <= shreg_nx;
      match_cnt <= match_cnt_nx;
      win_bit   <= win_bit_nx;
      win_err   <= win_err_nx;
      err_r     <= err_nx;
      lost_r    <= lost_nx;
    end
  end

  assign locked_o    = (state == CHK_LOCKED);
  assign err_o       = err_r;
  assign lock_lost_o = lost_r;

  assign err_inc = valid_i && (state == CHK_LOCKED) && bit_err;

  sat_counter #(
    .W(ERR_CNT_W)
  ) u_err_cnt (
    .clk  (clk_i),
    .rst_n(a_rst_n_i),
    .clr  (clr_i),
    .inc  (err_inc),
    .value(err_cnt_o)
  );

`ifdef PRBS9_CHK_BIT_CNT_EN
  logic bit_inc;

  assign bit_inc = valid_i && (state == CHK_LOCKED);

  sat_counter #(
    .W(ERR_CNT_W)
  ) u_bit_cnt (
    .clk  (clk_i),
    .rst_n(a_rst_n_i),
    .clr  (clr_i),
    .inc  (bit_inc),
    .value(bit_cnt_o)
  );
`else
  // Without the bit counter only the error count is available.
`endif

endmodule
